// File: rtl/uart_sched_pkg.sv
// Shared types and constants for uart_bus_scheduler.
// RX states exist only when UART_SCHED_RX_POLL_EN is defined.
package uart_sched_pkg;

    localparam int unsigned BUS_DW = 32;

    localparam logic [1:0] ADDR_ODR = 2'd0;
    localparam logic [1:0] ADDR_IDR = 2'd1;
    localparam logic [1:0] ADDR_BSR = 2'd2;
    localparam logic [1:0] ADDR_SR  = 2'd3;

    localparam int unsigned SR_BUSY = 0;
    localparam int unsigned SR_RXF  = 1;
    localparam int unsigned SR_FE   = 2;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_POLL      = 3'd2,
        ST_POLL_WAIT = 3'd3,
        ST_WRITE     = 3'd4
`ifdef UART_SCHED_RX_POLL_EN
        ,
        ST_RX_RD     = 3'd5,
        ST_RX_WAIT   = 3'd6,
        ST_RX_CLR    = 3'd7
`endif
    } state_e;

    typedef struct packed {
        logic              sel;
        logic              we;
        logic [1:0]        addr;
        logic [BUS_DW-1:0] data;
    } bus_t;

endpackage

// File: rtl/uart_bus_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after ptr_i wins.
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [$clog2(NREQ)-1:0] idx_o
);
    localparam int unsigned IW = $clog2(NREQ);

    logic [IW-1:0] j;

    // Walk from the farthest offset to the nearest so the nearest request overwrites last.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        j     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = IW'((32'(ptr_i) + NREQ - 1 - k) % NREQ);
            if (req_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end

endmodule

// File: rtl/uart_bus_scheduler.sv
// Schedules requester bytes onto a UART register bus (BSR init, SR busy polling, ODR writes).
// Optional RX servicing is compiled in with `define UART_SCHED_RX_POLL_EN.
module uart_bus_scheduler
    import uart_sched_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter logic [31:0] BAUD_DIV = 32'd144
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [NREQ*8-1:0] req_data_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic              sel_o,
    output logic              we_o,
    output logic [1:0]        addr_o,
    output logic [31:0]       data_o,
    input  logic [31:0]       data_i,
    output logic              rx_valid_o,
    output logic [7:0]        rx_data_o,
    output logic              rx_fe_o,
    input  logic              rx_ready_i,
    output logic              init_done_o
);
    localparam int unsigned IW = $clog2(NREQ);

    state_e          state_q, state_d;
    bus_t            bus_q, bus_d;
    logic [NREQ-1:0] ready_q, ready_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   win_q, win_d;
    logic [NREQ-1:0] win_oh_q, win_oh_d;
    logic [7:0]      byte_q, byte_d;
    logic            gnt_q, gnt_d;
    logic            init_done_q, init_done_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;

`ifdef UART_SCHED_RX_POLL_EN
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_fe_q, rx_fe_d;
    logic       fe_q, fe_d;
    logic       unused_data;
    assign unused_data = ^data_i[31:8];
`else
    logic       unused_data;
    assign unused_data = ^{data_i[31:1], rx_ready_i};
`endif

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_INIT;
        else       state_q <= state_d;
    end

    // Next-state logic; INIT stays one extra cycle so its BSR write is visible while in INIT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (bus_q.sel) state_d = ST_IDLE;
            ST_IDLE: begin
                if (|req_valid_i) state_d = ST_POLL;
`ifdef UART_SCHED_RX_POLL_EN
                else if (!rx_valid_q) state_d = ST_POLL;
`endif
            end
            ST_POLL: state_d = ST_POLL_WAIT;
            ST_POLL_WAIT: begin
                if (!gnt_q)                  state_d = ST_IDLE;
                else if (data_i[SR_BUSY])    state_d = ST_POLL;
                else                         state_d = ST_WRITE;
`ifdef UART_SCHED_RX_POLL_EN
                if (data_i[SR_RXF] && !rx_valid_q) state_d = ST_RX_RD;
`endif
            end
            ST_WRITE: state_d = ST_IDLE;
`ifdef UART_SCHED_RX_POLL_EN
            ST_RX_RD:   state_d = ST_RX_WAIT;
            ST_RX_WAIT: state_d = ST_RX_CLR;
            ST_RX_CLR:  state_d = gnt_q ? ST_POLL : ST_IDLE;
`endif
            default: state_d = ST_INIT;
        endcase
    end

    // Output/datapath logic: bus outputs are registered for the state being entered.
    always_comb begin
        bus_d       = '0;
        ready_d     = '0;
        ptr_d       = ptr_q;
        win_d       = win_q;
        win_oh_d    = win_oh_q;
        byte_d      = byte_q;
        gnt_d       = gnt_q;
        init_done_d = init_done_q;
`ifdef UART_SCHED_RX_POLL_EN
        rx_valid_d  = rx_valid_q & ~rx_ready_i;
        rx_data_d   = rx_data_q;
        rx_fe_d     = rx_fe_q;
        fe_d        = fe_q;
`endif
        if (state_q == ST_INIT && state_d == ST_IDLE) init_done_d = 1'b1;

        if (state_q == ST_IDLE && (|req_valid_i)) begin
            gnt_d    = 1'b1;
            win_d    = arb_idx;
            win_oh_d = arb_gnt;
            byte_d   = req_data_i[{arb_idx, 3'b000} +: 8];
        end

`ifdef UART_SCHED_RX_POLL_EN
        if (state_q == ST_POLL_WAIT && state_d == ST_RX_RD) fe_d = data_i[SR_FE];
        if (state_q == ST_RX_WAIT) begin
            rx_data_d  = data_i[7:0];
            rx_fe_d    = fe_q;
            rx_valid_d = 1'b1;
        end
`endif

        case (state_d)
            ST_INIT:  bus_d = '{sel: 1'b1, we: 1'b1, addr: ADDR_BSR, data: BAUD_DIV};
            ST_POLL:  bus_d = '{sel: 1'b1, we: 1'b0, addr: ADDR_SR, data: 32'd0};
            ST_WRITE: begin
                bus_d   = '{sel: 1'b1, we: 1'b1, addr: ADDR_ODR, data: {24'd0, byte_q}};
                ready_d = win_oh_q;
                gnt_d   = 1'b0;
                ptr_d   = (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
            end
`ifdef UART_SCHED_RX_POLL_EN
            ST_RX_RD:  bus_d = '{sel: 1'b1, we: 1'b0, addr: ADDR_IDR, data: 32'd0};
            ST_RX_CLR: bus_d = '{sel: 1'b1, we: 1'b1, addr: ADDR_SR, data: 32'd0};
`endif
            default: bus_d = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus_q       <= '0;
            ready_q     <= '0;
            ptr_q       <= '0;
            win_q       <= '0;
            win_oh_q    <= '0;
            byte_q      <= '0;
            gnt_q       <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            bus_q       <= bus_d;
            ready_q     <= ready_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            win_oh_q    <= win_oh_d;
            byte_q      <= byte_d;
            gnt_q       <= gnt_d;
            init_done_q <= init_done_d;
        end
    end

`ifdef UART_SCHED_RX_POLL_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            rx_fe_q    <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            rx_fe_q    <= rx_fe_d;
            fe_q       <= fe_d;
        end
    end

    assign rx_valid_o = rx_valid_q;
    assign rx_data_o  = rx_data_q;
    assign rx_fe_o    = rx_fe_q;
`else
    assign rx_valid_o = 1'b0;
    assign rx_data_o  = 8'd0;
    assign rx_fe_o    = 1'b0;
`endif

    assign sel_o       = bus_q.sel;
    assign we_o        = bus_q.we;
    assign addr_o      = bus_q.addr;
    assign data_o      = bus_q.data;
    assign req_ready_o = ready_q;
    assign init_done_o = init_done_q;

endmodule
